activation_table_writer: RTL and testbench
==========================================

ACTIVATION_TABLE_WRITER -- requirements
Module: activation_table_writer

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 16, the width of one tag and one activation entry.
REQ-002 The block SHALL have parameter INWIDTH, default 10, the table address width; table depth N = 2**INWIDTH.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 Ports:
 clock  in  1  rising-edge clock
 reset  in  1  synchronous, active-high reset
 load_start  in  1  single-cycle request to begin a table load
 wr_valid  in  1  entry available on wr_tag/wr_sig/wr_tanh
 wr_ready  out  1  block accepts an entry this cycle
 wr_tag  in  DATAWIDTH  signed fixed-point tag (x value)
 wr_sig  in  DATAWIDTH  sigmoid value for this tag
 wr_tanh  in  DATAWIDTH  tanh value for this tag
 mem_we  out  1  write strobe to tag and activation memories
 mem_addr  out  INWIDTH  write/read address
 tag_wdata  out  DATAWIDTH  tag memory write data
 act_wdata  out  2*DATAWIDTH  activation memory write data, {sig, tanh}
 tag_rdata  in  DATAWIDTH  tag memory read data, 1-cycle latency
 act_rdata  in  2*DATAWIDTH  activation memory read data, 1-cycle latency
 busy  out  1  load or verify in progress
 table_ready  out  1  table loaded and verified; lookup may run
 load_error  out  1  sticky error flag
 error_code  out  2  0 none, 1 non-monotonic tag, 2 checksum mismatch

Function
REQ-005 States SHALL be IDLE, LOAD, VERIFY, DONE, ERROR.
REQ-006 IDLE/DONE/ERROR + load_start SHALL go to LOAD next cycle, clearing address counter, checksum, table_ready, load_error, error_code.
REQ-007 load_start in LOAD or VERIFY SHALL be ignored.
REQ-008 wr_ready SHALL be 1 only in LOAD; an entry transfers on wr_valid && wr_ready.
REQ-009 Each transfer SHALL produce, on the next cycle, mem_we=1, mem_addr=entry index, tag_wdata=wr_tag, act_wdata={wr_sig, wr_tanh}; mem_we SHALL be 0 otherwise in LOAD.
REQ-010 Entry indices SHALL run 0..N-1 in transfer order; wr_valid gaps SHALL stall without side effects.
REQ-011 For index > 0, wr_tag SHALL be strictly greater (signed) than the previous accepted tag; a violation SHALL suppress that write, go to ERROR next cycle, error_code=1.
REQ-012 Load checksum SHALL be the modulo 2**(2*DATAWIDTH) sum over accepted entries of zero-extended tag plus {sig, tanh}.
REQ-013 Transfer of index N-1 SHALL go to VERIFY after its write cycle; the address counter SHALL not wrap into a second load.
REQ-014 VERIFY SHALL drive mem_addr 0..N-1 on consecutive cycles with mem_we=0, and accumulate a readback checksum from tag_rdata/act_rdata one cycle later.
REQ-015 After data for address N-1 is accumulated, equal checksums SHALL go to DONE; unequal SHALL go to ERROR with error_code=2.
REQ-016 table_ready SHALL be 1 only in DONE; busy SHALL be 1 only in LOAD and VERIFY.
REQ-017 load_error SHALL be 1 exactly when error_code != 0, held until next load_start or reset.

Reset
REQ-018 Reset SHALL force IDLE and zero wr_ready, mem_we, mem_addr, tag_wdata, act_wdata, busy, table_ready, load_error, error_code, counter and both checksums, overriding all other inputs including mid-load and mid-verify.
REQ-019 Memory contents SHALL not be cleared by reset; table_ready=0 after reset marks them invalid.

Structure
REQ-020 State encoding, error-code constants and a table-depth function of INWIDTH SHALL live in shared package activation_pkg.
REQ-021 The entry/readback address counter SHALL be an instance of the existing up_counter (COUNTER_WIDTH=INWIDTH), using its reset and load_enable for clearing.

Verification (bench uses INWIDTH=3, N=8, memory model with 1-cycle read)
REQ-022 Tags -8,-4,-2,-1,0,1,3,7 with arbitrary sig/tanh, wr_valid continuous -> 8 writes at addr 0..7, VERIFY 8 cycles, table_ready=1, error_code=0.
REQ-023 Same stream with wr_valid low every other cycle -> identical memory contents and DONE; no write during gaps.
REQ-024 Tag at index 4 equal to index 3 (both 0) -> no write at addr 4, ERROR, error_code=1, wr_ready=0 next cycle.
REQ-025 Memory model corrupts addr 5 tag bit 0 after load -> ERROR, error_code=2, table_ready=0.
REQ-026 reset asserted after 3 transfers -> all outputs zero next cycle; fresh load_start then full load reaches DONE.
REQ-027 load_start pulsed mid-LOAD and mid-VERIFY -> ignored; load_start in DONE -> table_ready=0 next cycle, new LOAD begins at addr 0.

Source files
------------

// File: rtl/activation_pkg.sv
// Shared definitions for the activation table writer: FSM states, error codes
// and the table depth derived from the address width.
package activation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE          = 2'd0;
  localparam logic [1:0] ERR_NON_MONOTONIC = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM      = 2'd2;

  function automatic int unsigned table_depth(input int unsigned inwidth);
    return 32'd1 << inwidth;
  endfunction

endpackage

// File: rtl/up_counter.sv
// Generic up counter with synchronous reset and a load port that takes
// priority over counting.
module up_counter #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_enable,
  input  logic [COUNTER_WIDTH-1:0] load_value,
  input  logic                     enable,
  output logic [COUNTER_WIDTH-1:0] count
);

  logic [COUNTER_WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset)            count_q <= '0;
    else if (load_enable) count_q <= load_value;
    else if (enable)      count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/activation_table_writer.sv
// Streams (tag, sigmoid, tanh) entries into the lookup memories, enforcing
// strictly increasing tags, then reads the table back and compares checksums.
module activation_table_writer
  import activation_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int INWIDTH   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [DATAWIDTH-1:0]   wr_tag,
  input  logic [DATAWIDTH-1:0]   wr_sig,
  input  logic [DATAWIDTH-1:0]   wr_tanh,
  output logic                   mem_we,
  output logic [INWIDTH-1:0]     mem_addr,
  output logic [DATAWIDTH-1:0]   tag_wdata,
  output logic [2*DATAWIDTH-1:0] act_wdata,
  input  logic [DATAWIDTH-1:0]   tag_rdata,
  input  logic [2*DATAWIDTH-1:0] act_rdata,
  output logic                   busy,
  output logic                   table_ready,
  output logic                   load_error,
  output logic [1:0]             error_code
);

  localparam int                 SW        = 2 * DATAWIDTH;
  localparam int unsigned        DEPTH     = table_depth(INWIDTH);
  localparam logic [INWIDTH-1:0] LAST_ADDR = INWIDTH'(DEPTH - 1);

  state_e               state_q;
  logic [INWIDTH-1:0]   count;
  logic                 last_q, issue_done_q, rd_valid_q, rd_last_q;
  logic [DATAWIDTH-1:0] prev_tag_q;
  logic [SW-1:0]        load_sum_q, rb_sum_q, rb_sum_d;
  logic                 mem_we_q;
  logic [INWIDTH-1:0]   mem_addr_q;
  logic [DATAWIDTH-1:0] tag_wdata_q;
  logic [SW-1:0]        act_wdata_q;
  logic [1:0]           error_code_q;

  logic start_ok, transfer, tag_ok, wr_done, issue, cnt_clear, cnt_enable;

  assign start_ok   = load_start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign transfer   = wr_valid && wr_ready;
  assign tag_ok     = (count == '0) || ($signed(wr_tag) > $signed(prev_tag_q));
  assign wr_done    = (state_q == ST_LOAD) && last_q;
  assign issue      = (state_q == ST_VERIFY) && !issue_done_q;
  assign cnt_clear  = start_ok || wr_done;
  assign cnt_enable = ((state_q == ST_LOAD) && transfer && tag_ok) ||
                      (issue && (count != LAST_ADDR));
  assign rb_sum_d   = rb_sum_q + SW'(tag_rdata) + act_rdata;

  up_counter #(.COUNTER_WIDTH(INWIDTH)) u_addr_counter (
    .clock       (clock),
    .reset       (reset),
    .load_enable (cnt_clear),
    .load_value  ('0),
    .enable      (cnt_enable),
    .count       (count)
  );

  // NOTE: the tag/activation memories live outside and are deliberately not reset; table_ready marks them valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b0;
      issue_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      prev_tag_q   <= '0;
      load_sum_q   <= '0;
      rb_sum_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      tag_wdata_q  <= '0;
      act_wdata_q  <= '0;
      error_code_q <= ERR_NONE;
    end else begin
      mem_we_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (load_start) begin
            state_q      <= ST_LOAD;
            last_q       <= 1'b0;
            load_sum_q   <= '0;
            rb_sum_q     <= '0;
            error_code_q <= ERR_NONE;
          end
        end
        ST_LOAD: begin
          // last_q holds off further entries while the final write drains
          if (last_q) begin
            state_q      <= ST_VERIFY;
            mem_addr_q   <= '0;
            issue_done_q <= 1'b0;
            rb_sum_q     <= '0;
          end else if (transfer) begin
            if (!tag_ok) begin
              state_q      <= ST_ERROR;
              error_code_q <= ERR_NON_MONOTONIC;
            end else begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= count;
              tag_wdata_q <= wr_tag;
              act_wdata_q <= {wr_sig, wr_tanh};
              prev_tag_q  <= wr_tag;
              load_sum_q  <= load_sum_q + SW'(wr_tag) + {wr_sig, wr_tanh};
              if (count == LAST_ADDR) last_q <= 1'b1;
            end
          end
        end
        ST_VERIFY: begin
          if (issue) begin
            rd_valid_q <= 1'b1;
            rd_last_q  <= (count == LAST_ADDR);
            if (count == LAST_ADDR) issue_done_q <= 1'b1;
            else                    mem_addr_q   <= count + 1'b1;
          end
          // read data trails the address by one cycle
          if (rd_valid_q) begin
            rb_sum_q <= rb_sum_d;
            if (rd_last_q) begin
              if (rb_sum_d == load_sum_q) begin
                state_q <= ST_DONE;
              end else begin
                state_q      <= ST_ERROR;
                error_code_q <= ERR_CHECKSUM;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready    = (state_q == ST_LOAD) && !last_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign tag_wdata   = tag_wdata_q;
  assign act_wdata   = act_wdata_q;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
  assign table_ready = (state_q == ST_DONE);
  assign error_code  = error_code_q;
  assign load_error  = (error_code_q != ERR_NONE);

endmodule

// File: tb/tb_activation_table_writer.sv
// Self-checking bench for activation_table_writer with an 8-entry memory model
// and a stream-level reference model of the expected writes and outcome.
module tb_activation_table_writer;

  localparam int DW = 16;
  localparam int IW = 3;
  localparam int N  = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            load_start = 1'b0;
  logic            wr_valid = 1'b0;
  logic [DW-1:0]   wr_tag = '0, wr_sig = '0, wr_tanh = '0;
  logic            wr_ready, mem_we, busy, table_ready, load_error;
  logic [IW-1:0]   mem_addr;
  logic [DW-1:0]   tag_wdata, tag_rdata;
  logic [2*DW-1:0] act_wdata, act_rdata;
  logic [1:0]      error_code;

  int n_cmp = 0;
  int n_bad = 0;

  activation_table_writer #(.DATAWIDTH(DW), .INWIDTH(IW)) dut (
    .clock       (clock),
    .reset       (reset),
    .load_start  (load_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_tag      (wr_tag),
    .wr_sig      (wr_sig),
    .wr_tanh     (wr_tanh),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .tag_wdata   (tag_wdata),
    .act_wdata   (act_wdata),
    .tag_rdata   (tag_rdata),
    .act_rdata   (act_rdata),
    .busy        (busy),
    .table_ready (table_ready),
    .load_error  (load_error),
    .error_code  (error_code)
  );

  always #5 clock = ~clock;

  // Memory model: synchronous write, 1-cycle read, optional read-side corruption of one tag bit.
  logic [DW-1:0]   tag_mem [N];
  logic [2*DW-1:0] act_mem [N];
  int              corrupt_addr = -1;

  initial begin
    for (int i = 0; i < N; i++) begin
      tag_mem[i] = '0;
      act_mem[i] = '0;
    end
  end

  always @(posedge clock) begin
    if (mem_we) begin
      tag_mem[mem_addr] <= tag_wdata;
      act_mem[mem_addr] <= act_wdata;
    end
    tag_rdata <= tag_mem[mem_addr] ^ ((int'(mem_addr) == corrupt_addr) ? 16'd1 : 16'd0);
    act_rdata <= act_mem[mem_addr];
  end

  // Monitor, sampled mid-cycle: logs writes, verify addresses and writes not preceded by a transfer.
  int              wq_addr [$];
  logic [DW-1:0]   wq_tag  [$];
  logic [2*DW-1:0] wq_act  [$];
  int              vq      [$];
  int              stray = 0;
  logic            xfer_pending = 1'b0;

  always @(negedge clock) begin
    #2;
    if (mem_we) begin
      wq_addr.push_back(int'(mem_addr));
      wq_tag.push_back(tag_wdata);
      wq_act.push_back(act_wdata);
      if (!xfer_pending) stray++;
    end
    if (busy && !wr_ready && !mem_we) vq.push_back(int'(mem_addr));
    xfer_pending = wr_valid && wr_ready;
  end

  logic [DW-1:0] e_tag [N];
  logic [DW-1:0] e_sig [N];
  logic [DW-1:0] e_tanh[N];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: index of the first tag not strictly above its predecessor, N if none.
  function automatic int first_violation();
    for (int i = 1; i < N; i++)
      if ($signed(e_tag[i]) <= $signed(e_tag[i-1])) return i;
    return N;
  endfunction

  task automatic set_tags(input int t0, t1, t2, t3, t4, t5, t6, t7);
    int t[N];
    t = '{t0, t1, t2, t3, t4, t5, t6, t7};
    for (int i = 0; i < N; i++) begin
      e_tag[i]  = 16'(t[i]);
      e_sig[i]  = 16'($urandom);
      e_tanh[i] = 16'($urandom);
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "/wr_ready"},    wr_ready,    0);
    check({nm, "/mem_we"},      mem_we,      0);
    check({nm, "/mem_addr"},    mem_addr,    0);
    check({nm, "/tag_wdata"},   tag_wdata,   0);
    check({nm, "/act_wdata"},   act_wdata,   0);
    check({nm, "/busy"},        busy,        0);
    check({nm, "/table_ready"}, table_ready, 0);
    check({nm, "/load_error"},  load_error,  0);
    check({nm, "/error_code"},  error_code,  0);
  endtask

  task automatic start_load();
    @(negedge clock);
    load_start = 1'b1;
    wq_addr.delete(); wq_tag.delete(); wq_act.delete(); vq.delete();
    stray = 0;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Offers entries from the current negedge; returns on the cycle after the last accepted one.
  task automatic feed(input bit gap, input int stop_at, input int start_mid);
    int idx = 0;
    int cyc = 0;
    while (idx < stop_at && cyc < 200 && busy) begin
      load_start = (idx == start_mid);
      if (gap && (cyc % 2 == 1)) begin
        wr_valid = 1'b0;
      end else begin
        wr_valid = 1'b1;
        wr_tag   = e_tag[idx];
        wr_sig   = e_sig[idx];
        wr_tanh  = e_tanh[idx];
      end
      if (wr_valid && wr_ready) idx++;
      @(negedge clock);
      cyc++;
    end
    wr_valid   = 1'b0;
    load_start = 1'b0;
    if (cyc >= 200) check("feed_timeout", 1, 0);
  endtask

  task automatic wait_idle(input string nm);
    for (int c = 0; c < 100 && busy; c++) @(negedge clock);
    if (busy) check({nm, "/idle_timeout"}, 1, 0);
  endtask

  task automatic run(input string nm, input bit gap, input int start_mid,
                     input bit start_verify, input int corrupt);
    int         v;
    logic [1:0] exp_code;
    corrupt_addr = corrupt;
    v = first_violation();
    exp_code = (v < N) ? 2'd1 : ((corrupt >= 0) ? 2'd2 : 2'd0);
    start_load();
    check({nm, "/load_ready"},  wr_ready,    1);
    check({nm, "/load_tready"}, table_ready, 0);
    feed(gap, N, start_mid);
    if (v < N) begin
      check({nm, "/wr_ready_after_viol"}, wr_ready,   0);
      check({nm, "/code_after_viol"},     error_code, 1);
    end else if (start_verify) begin
      repeat (3) @(negedge clock);
      load_start = 1'b1;
      @(negedge clock);
      load_start = 1'b0;
    end
    wait_idle(nm);
    check({nm, "/nwrites"}, wq_addr.size(), v);
    for (int k = 0; k < v && k < wq_addr.size(); k++) begin
      check($sformatf("%s/waddr%0d", nm, k), wq_addr[k], k);
      check($sformatf("%s/wtag%0d",  nm, k), wq_tag[k],  e_tag[k]);
      check($sformatf("%s/wact%0d",  nm, k), wq_act[k],  {e_sig[k], e_tanh[k]});
    end
    check({nm, "/stray_writes"}, stray,       0);
    check({nm, "/error_code"},   error_code,  exp_code);
    check({nm, "/load_error"},   load_error,  exp_code != 0);
    check({nm, "/table_ready"},  table_ready, exp_code == 0);
    if (v == N) begin
      check({nm, "/verify_len"}, vq.size() >= N, 1);
      for (int k = 0; k < N && k < vq.size(); k++)
        check($sformatf("%s/vaddr%0d", nm, k), vq[k], k);
      for (int k = 0; k < N; k++) begin
        check($sformatf("%s/mtag%0d", nm, k), tag_mem[k], e_tag[k]);
        check($sformatf("%s/mact%0d", nm, k), act_mem[k], {e_sig[k], e_tanh[k]});
      end
    end else begin
      check({nm, "/no_verify"}, vq.size(), 0);
    end
    corrupt_addr = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, p, v;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;

    set_tags(-8, -4, -2, -1, 0, 1, 3, 7);
    run("basic", 1'b0, -1, 1'b0, -1);
    run("gap",   1'b1, -1, 1'b0, -1);

    set_tags(-8, -4, -2, 0, 0, 1, 3, 7);
    run("dup_tag", 1'b0, -1, 1'b0, -1);

    set_tags(-8, -4, -2, -1, 0, 1, 3, 7);
    run("corrupt", 1'b0, -1, 1'b0, 5);

    start_load();
    feed(1'b0, 3, -1);
    reset = 1'b1;
    @(negedge clock);
    check_all_zero("mid_reset");
    reset = 1'b0;
    run("after_reset",  1'b0, -1, 1'b0, -1);
    run("ignore_start", 1'b0, 2,  1'b1, -1);
    run("from_done",    1'b0, -1, 1'b0, -1);

    for (int it = 0; it < 6; it++) begin
      t = -200 + int'($urandom_range(0, 100));
      for (int i = 0; i < N; i++) begin
        e_tag[i]  = 16'(t);
        e_sig[i]  = 16'($urandom);
        e_tanh[i] = 16'($urandom);
        t += int'($urandom_range(1, 300));
      end
      if (it % 2 == 1) begin
        v = int'($urandom_range(1, N - 1));
        p = int'($signed(e_tag[v-1])) - int'($urandom_range(0, 5));
        e_tag[v] = 16'(p);
      end
      run($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), -1, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
